mem_shuf_seq: RTL and testbench
===============================

MEM_SHUF_SEQ -- requirements
Module: mem_shuf_seq

Interface
REQ-001 clk_i  input  1  sole clock; all state on rising edge.
REQ-002 rst_ni  input  1  asynchronous, active-low reset.
REQ-003 req_valid_i / req_ready_o  in/out  1/1  load-request handshake.
REQ-004 req_vl_i  input  vlen_t  element count; req_sew_i  input  vew_e  element width; req_offset_i  input  bytes_cnt_t  byte offset of element 0 in first memory word.
REQ-005 mem_valid_i / mem_ready_o  in/out  1/1  memory beat handshake; mem_data_i  input  vrf_data_t  one VRF-width word.
REQ-006 shuf_data_o vrf_data_t, shuf_sel_o [LogNrLane-1:0], shuf_first_o 1, shuf_skip_first_o bytes_cnt_t, shuf_last_o 1, shuf_skip_last_o bytes_cnt_t, shuf_sew_o vew_e  outputs  drive the external shuffler.
REQ-007 shuf_data_i  input  vrf_data_t[NrLane]; shuf_mask_i  input  vrf_strb_t[NrLane]  combinational shuffler result for the current beat.
REQ-008 lane_valid_o  output  1; lane_ready_i  input  1  all-lane writeback handshake; lane_data_o vrf_data_t[NrLane], lane_strb_o vrf_strb_t[NrLane]  outputs.
REQ-009 done_o  output  1  one-cycle pulse on request completion.

Function
REQ-010 States IDLE, BEAT, FLUSH; in IDLE req_ready_o=1, mem_ready_o=0, lane_valid_o=0.
REQ-011 Request handshake latches sew, offset, total=vl<<sew (36-bit unsigned), end=offset+total; beats=ceil(end/VRFWordWidthB).
REQ-012 vl=0: request accepted, state stays IDLE, done_o pulses next cycle, no beat consumed.
REQ-013 BEAT: mem_ready_o=1; shuf_* outputs reflect mem_data_i and current counters combinationally (zero cycles).
REQ-014 shuf_sel_o starts at 0 per request, increments per accepted beat, wraps NrLane-1 -> 0.
REQ-015 shuf_first_o=1 only for beat 0 with shuf_skip_first_o=offset; else skip_first=0.
REQ-016 shuf_last_o=1 only for final beat with shuf_skip_last_o=(VRFWordWidthB - end mod VRFWordWidthB) mod VRFWordWidthB; else 0; single-beat request asserts both.
REQ-017 On accepted beat, accumulator byte b of lane l takes shuf_data_i[l][b] where shuf_mask_i[l][b]=1; strobes OR-merge.
REQ-018 Beat with sel=NrLane-1 or final beat: next state FLUSH.
REQ-019 FLUSH: lane_valid_o=1, mem_ready_o=0; lane_data_o/lane_strb_o stable until lane_ready_i; on handshake accumulator and strobes clear; next BEAT if beats remain, else IDLE with done_o pulse same cycle as transition.
REQ-020 lane_strb_o of a flush covers only bytes inside [offset, end).
REQ-021 req_ready_o=0 outside IDLE; new request never overlaps.

Reset
REQ-022 Async assertion anytime (incl. mid-FLUSH): state IDLE, counters/accumulator/strobes 0, all valid/ready/done outputs 0 except req_ready_o=1 after release; pending beat discarded.

Configuration
REQ-023 MEM_SHUF_SEQ_STALL_CNT_EN defined: output stall_cnt_o [31:0] counts FLUSH cycles with lane_ready_i=0, saturating at all-ones, reset 0, cleared on request handshake.
REQ-024 Undefined: stall_cnt_o port and counter absent; all other behaviour identical.

Structure
REQ-025 State enum and beat-count width constant in rvv_pkg; vrf_data_t, vrf_strb_t, bytes_cnt_t, vew_e, NrLane, LogNrLane, VRFWordWidthB taken from existing packages.
REQ-026 Shuffler instantiated outside; one sub-module mem_shuf_acc (lane accumulator, merge/clear) is natural.

Verification (NrLane=4, VRFWordWidthB=8)
REQ-027 vl=16 EW8 offset 0 -> 2 beats sel 0,1; beat0 first skip 0, beat1 last skip 0; one flush, strb all 1 in lanes 0-1; done_o.
REQ-028 vl=1 EW16 offset 2 -> 1 beat first&last, skip_first 2, skip_last 4; lane0 strb 0x0C.
REQ-029 vl=40 EW8 offset 0 -> 5 beats; flush after sel=3 beat and after 5th beat (sel 0); done_o after second flush.
REQ-030 vl=16 EW8, lane_ready_i low 3 cycles in FLUSH -> mem_ready_o low, data stable, stall_cnt_o=3 (macro defined).
REQ-031 vl=0 -> no mem_ready_o, done_o one cycle after handshake.
REQ-032 rst_ni low mid-FLUSH -> lane_valid_o 0 immediately; after release req_ready_o=1, next request sel restarts 0.

Source files
------------

// File: rtl/mem_shuf_seq_pkg.sv
// Shared types, sizes and state encoding for the memory-load shuffle sequencer.
package mem_shuf_seq_pkg;

  localparam int unsigned NrLane           = 4;
  localparam int unsigned LogNrLane        = 2;
  localparam int unsigned VRFWordWidthB    = 8;
  localparam int unsigned LogVRFWordWidthB = 3;
  localparam int unsigned VlenW            = 32;
  localparam int unsigned TotalW           = 36;
  localparam int unsigned EndW             = TotalW + 1;
  localparam int unsigned BeatCntW         = EndW + 1 - LogVRFWordWidthB;

  typedef logic [8*VRFWordWidthB-1:0]  vrf_data_t;
  typedef logic [VRFWordWidthB-1:0]    vrf_strb_t;
  typedef logic [LogVRFWordWidthB-1:0] bytes_cnt_t;
  typedef logic [VlenW-1:0]            vlen_t;
  typedef logic [BeatCntW-1:0]         beat_cnt_t;

  typedef enum logic [1:0] {EW8 = 2'd0, EW16 = 2'd1, EW32 = 2'd2, EW64 = 2'd3} vew_e;

  typedef enum logic [1:0] {StIdle, StBeat, StFlush} state_e;

  // Number of memory words touched by bytes [0, end_b).
  function automatic beat_cnt_t calc_beats(logic [EndW-1:0] end_b);
    logic [EndW:0] rnd;
    rnd = {1'b0, end_b} + (EndW + 1)'(VRFWordWidthB - 1);
    return beat_cnt_t'(rnd >> LogVRFWordWidthB);
  endfunction

endpackage

// File: rtl/mem_shuf_seq_acc.sv
// Per-lane byte accumulator: masked merge of shuffler output, cleared on writeback.
module mem_shuf_acc
  import mem_shuf_seq_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      merge_i,
  input  logic      clr_i,
  input  vrf_data_t shuf_data_i [NrLane],
  input  vrf_strb_t shuf_mask_i [NrLane],
  output vrf_data_t lane_data_o [NrLane],
  output vrf_strb_t lane_strb_o [NrLane]
);

  vrf_data_t data_q [NrLane];
  vrf_data_t data_d [NrLane];
  vrf_strb_t strb_q [NrLane];
  vrf_strb_t strb_d [NrLane];

  always_comb begin
    for (int l = 0; l < NrLane; l++) begin
      data_d[l] = data_q[l];
      strb_d[l] = strb_q[l];
      if (clr_i) begin
        data_d[l] = '0;
        strb_d[l] = '0;
      end else if (merge_i) begin
        for (int b = 0; b < VRFWordWidthB; b++) begin
          if (shuf_mask_i[l][b]) data_d[l][8*b +: 8] = shuf_data_i[l][8*b +: 8];
        end
        strb_d[l] = strb_q[l] | shuf_mask_i[l];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '{default: '0};
      strb_q <= '{default: '0};
    end else begin
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  assign lane_data_o = data_q;
  assign lane_strb_o = strb_q;

endmodule

// File: rtl/mem_shuf_seq.sv
// Sequences memory beats through an external shuffler into per-lane writeback words.
// Optional MEM_SHUF_SEQ_STALL_CNT_EN adds stall_cnt_o counting back-pressured flush cycles.
module mem_shuf_seq
  import mem_shuf_seq_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  vlen_t                req_vl_i,
  input  vew_e                 req_sew_i,
  input  bytes_cnt_t           req_offset_i,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  vrf_data_t            mem_data_i,
  output vrf_data_t            shuf_data_o,
  output logic [LogNrLane-1:0] shuf_sel_o,
  output logic                 shuf_first_o,
  output bytes_cnt_t           shuf_skip_first_o,
  output logic                 shuf_last_o,
  output bytes_cnt_t           shuf_skip_last_o,
  output vew_e                 shuf_sew_o,
  input  vrf_data_t            shuf_data_i [NrLane],
  input  vrf_strb_t            shuf_mask_i [NrLane],
  output logic                 lane_valid_o,
  input  logic                 lane_ready_i,
  output vrf_data_t            lane_data_o [NrLane],
  output vrf_strb_t            lane_strb_o [NrLane],
`ifdef MEM_SHUF_SEQ_STALL_CNT_EN
  output logic [31:0]          stall_cnt_o,
`endif
  output logic                 done_o
);

  state_e               state_q;
  vew_e                 sew_q;
  bytes_cnt_t           offset_q;
  bytes_cnt_t           end_mod_q;
  beat_cnt_t            beats_q;
  beat_cnt_t            beat_idx_q;
  logic [LogNrLane-1:0] sel_q;
  logic                 req_ready_q, mem_ready_q, lane_valid_q, done_q;

  logic              req_hs, beat_hs, flush_hs;
  logic              is_first, is_last;
  logic [TotalW-1:0] total;
  logic [EndW-1:0]   end_b;

  assign req_hs   = req_valid_i & req_ready_q;
  assign beat_hs  = mem_valid_i & mem_ready_q;
  assign flush_hs = lane_valid_q & lane_ready_i;
  assign total    = TotalW'(req_vl_i) << req_sew_i;
  assign end_b    = EndW'(req_offset_i) + EndW'(total);
  assign is_first = (beat_idx_q == '0);
  assign is_last  = (beat_idx_q == beats_q - beat_cnt_t'(1));

  assign shuf_data_o       = mem_data_i;
  assign shuf_sel_o        = sel_q;
  assign shuf_sew_o        = sew_q;
  assign shuf_first_o      = is_first;
  assign shuf_skip_first_o = is_first ? offset_q : '0;
  assign shuf_last_o       = is_last;
  // Bytes past the request end in the final word: (W - end mod W) mod W.
  assign shuf_skip_last_o  = is_last ? bytes_cnt_t'(~end_mod_q + bytes_cnt_t'(1)) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sew_q        <= EW8;
      offset_q     <= '0;
      end_mod_q    <= '0;
      beats_q      <= '0;
      beat_idx_q   <= '0;
      sel_q        <= '0;
      req_ready_q  <= 1'b0;
      mem_ready_q  <= 1'b0;
      lane_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_hs) begin
            sew_q      <= req_sew_i;
            offset_q   <= req_offset_i;
            end_mod_q  <= end_b[LogVRFWordWidthB-1:0];
            beats_q    <= calc_beats(end_b);
            beat_idx_q <= '0;
            sel_q      <= '0;
            if (req_vl_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= StBeat;
              req_ready_q <= 1'b0;
              mem_ready_q <= 1'b1;
            end
          end
        end
        StBeat: begin
          if (beat_hs) begin
            beat_idx_q <= beat_idx_q + beat_cnt_t'(1);
            sel_q      <= (sel_q == LogNrLane'(NrLane - 1)) ? '0 : sel_q + LogNrLane'(1);
            if (sel_q == LogNrLane'(NrLane - 1) || is_last) begin
              state_q      <= StFlush;
              mem_ready_q  <= 1'b0;
              lane_valid_q <= 1'b1;
            end
          end
        end
        StFlush: begin
          if (lane_ready_i) begin
            lane_valid_q <= 1'b0;
            if (beat_idx_q == beats_q) begin
              state_q     <= StIdle;
              done_q      <= 1'b1;
              req_ready_q <= 1'b1;
            end else begin
              state_q     <= StBeat;
              mem_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign mem_ready_o  = mem_ready_q;
  assign lane_valid_o = lane_valid_q;
  assign done_o       = done_q;

  mem_shuf_acc u_acc (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .merge_i     (beat_hs),
    .clr_i       (flush_hs),
    .shuf_data_i (shuf_data_i),
    .shuf_mask_i (shuf_mask_i),
    .lane_data_o (lane_data_o),
    .lane_strb_o (lane_strb_o)
  );

`ifdef MEM_SHUF_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (req_hs) begin
      stall_cnt_q <= '0;
    end else if (lane_valid_q && !lane_ready_i && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_shuf_seq.sv
// Directed table-driven bench for mem_shuf_seq with a simple lane-select shuffler model.
module tb_mem_shuf_seq;
  import mem_shuf_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic        req_valid, req_ready;
  vlen_t       req_vl;
  vew_e        req_sew;
  bytes_cnt_t  req_off;
  logic        mem_valid, mem_ready;
  vrf_data_t   mem_data;
  vrf_data_t   shuf_data_o;
  logic [1:0]  shuf_sel;
  logic        shuf_first, shuf_last;
  bytes_cnt_t  shuf_sf, shuf_sl;
  vew_e        shuf_sew;
  vrf_data_t   shuf_data [NrLane];
  vrf_strb_t   shuf_mask [NrLane];
  logic        lane_valid, lane_ready;
  vrf_data_t   lane_data [NrLane];
  vrf_strb_t   lane_strb [NrLane];
  logic        done;
`ifdef MEM_SHUF_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  mem_shuf_seq dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_vl_i          (req_vl),
    .req_sew_i         (req_sew),
    .req_offset_i      (req_off),
    .mem_valid_i       (mem_valid),
    .mem_ready_o       (mem_ready),
    .mem_data_i        (mem_data),
    .shuf_data_o       (shuf_data_o),
    .shuf_sel_o        (shuf_sel),
    .shuf_first_o      (shuf_first),
    .shuf_skip_first_o (shuf_sf),
    .shuf_last_o       (shuf_last),
    .shuf_skip_last_o  (shuf_sl),
    .shuf_sew_o        (shuf_sew),
    .shuf_data_i       (shuf_data),
    .shuf_mask_i       (shuf_mask),
    .lane_valid_o      (lane_valid),
    .lane_ready_i      (lane_ready),
    .lane_data_o       (lane_data),
    .lane_strb_o       (lane_strb),
`ifdef MEM_SHUF_SEQ_STALL_CNT_EN
    .stall_cnt_o       (stall_cnt),
`endif
    .done_o            (done)
  );

  // Shuffler model: the beat lands byte-for-byte in lane sel, trimmed by the skip counts.
  always_comb begin
    vrf_strb_t m;
    m = 8'hFF;
    if (shuf_first) m = m & (8'hFF << shuf_sf);
    if (shuf_last)  m = m & (8'hFF >> shuf_sl);
    for (int l = 0; l < NrLane; l++) begin
      shuf_data[l] = shuf_data_o;
      shuf_mask[l] = '0;
    end
    shuf_mask[shuf_sel] = m;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vrf_data_t pat(input int k);
    vrf_data_t p;
    for (int b = 0; b < 8; b++) p[8*b +: 8] = 8'((k * 16 + b) & 255);
    return p;
  endfunction

  int         nb, nf, done_seen;
  logic [1:0] rec_sel   [16];
  logic       rec_first [16];
  logic       rec_last  [16];
  bytes_cnt_t rec_sf    [16];
  bytes_cnt_t rec_sl    [16];
  vrf_strb_t  rec_strb  [4][4];
  vrf_data_t  rec_data  [4][4];

  task automatic run_req(input int vl, input vew_e sew, input int off);
    int cyc;
    nb = 0; nf = 0; done_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_vl = vlen_t'(vl); req_sew = sew; req_off = bytes_cnt_t'(off);
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (done_seen == 0 && cyc < 200) begin
      if (done) begin
        done_seen = 1;
      end else begin
        if (mem_ready) begin
          if (nb < 16) begin
            rec_sel[nb] = shuf_sel; rec_first[nb] = shuf_first; rec_last[nb] = shuf_last;
            rec_sf[nb] = shuf_sf; rec_sl[nb] = shuf_sl;
          end
          mem_valid = 1'b1; mem_data = pat(nb); nb++;
        end else mem_valid = 1'b0;
        if (lane_valid) begin
          if (nf < 4) for (int l = 0; l < 4; l++) begin
            rec_strb[nf][l] = lane_strb[l]; rec_data[nf][l] = lane_data[l];
          end
          lane_ready = 1'b1; nf++;
        end else lane_ready = 1'b0;
        @(negedge clk); cyc++;
      end
    end
    mem_valid = 1'b0; lane_ready = 1'b0;
  endtask

  task automatic to_flush(output int ok);
    int cyc = 0;
    int k = 0;
    ok = 0;
    while (cyc < 50 && ok == 0) begin
      if (lane_valid) ok = 1;
      else begin
        mem_valid = mem_ready; mem_data = pat(k);
        if (mem_ready) k++;
        @(negedge clk); cyc++;
      end
    end
    mem_valid = 1'b0;
  endtask

  typedef struct {
    int   vl;
    vew_e sew;
    int   off;
    int   beats;
    int   flushes;
    int   sf;
    int   sl;
    int   s0;
    int   s1;
    int   last_sel;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int err, nbr, nfr, tot, ok, pos;
    vrf_data_t snap_d;
    vrf_strb_t snap_s;
    vecs[0] = '{16, EW8,  0, 2, 1, 0, 0, 8'hFF, 8'hFF, 1};
    vecs[1] = '{1,  EW16, 2, 1, 1, 2, 4, 8'h0C, 8'h00, 0};
    vecs[2] = '{40, EW8,  0, 5, 2, 0, 0, 8'hFF, 8'hFF, 0};
    vecs[3] = '{3,  EW32, 5, 3, 1, 5, 7, 8'hE0, 8'hFF, 2};
    vecs[4] = '{2,  EW64, 0, 2, 1, 0, 0, 8'hFF, 8'hFF, 1};
    vecs[5] = '{0,  EW8,  3, 0, 0, 0, 0, 0,     0,     0};

    rst_ni = 1'b0; req_valid = 1'b0; req_vl = '0; req_sew = EW8; req_off = '0;
    mem_valid = 1'b0; mem_data = '0; lane_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready_in_reset", int'(req_ready), 0);
    check("rst_mem_ready", int'(mem_ready), 0);
    check("rst_lane_valid", int'(lane_valid), 0);
    check("rst_done", int'(done), 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_req_ready_after", int'(req_ready), 1);
    check("rst_strb0", int'(lane_strb[0]), 0);

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].vl, vecs[i].sew, vecs[i].off);
      check($sformatf("v%0d_done", i), done_seen, 1);
      check($sformatf("v%0d_beats", i), nb, vecs[i].beats);
      check($sformatf("v%0d_flushes", i), nf, vecs[i].flushes);
      nbr = (nb > 16) ? 16 : nb;
      nfr = (nf > 4) ? 4 : nf;
      if (nbr > 0) begin
        err = 0;
        for (int k = 0; k < nbr; k++) begin
          if (int'(rec_sel[k]) != k % 4) err++;
          if (rec_first[k] != (k == 0)) err++;
          if (rec_last[k] != (k == nb - 1)) err++;
          if (k != 0 && rec_sf[k] != 0) err++;
          if (k != nb - 1 && rec_sl[k] != 0) err++;
        end
        check($sformatf("v%0d_ctrl_seq", i), err, 0);
        check($sformatf("v%0d_skip_first", i), int'(rec_sf[0]), vecs[i].sf);
        check($sformatf("v%0d_skip_last", i), int'(rec_sl[nbr-1]), vecs[i].sl);
        check($sformatf("v%0d_last_sel", i), int'(rec_sel[nbr-1]), vecs[i].last_sel);
      end
      if (nfr > 0) begin
        check($sformatf("v%0d_strb_l0", i), int'(rec_strb[0][0]), vecs[i].s0);
        check($sformatf("v%0d_strb_l1", i), int'(rec_strb[0][1]), vecs[i].s1);
        tot = vecs[i].vl << int'(vecs[i].sew);
        err = 0;
        for (int f = 0; f < nfr; f++)
          for (int l = 0; l < 4; l++)
            for (int b = 0; b < 8; b++) begin
              pos = (f * 4 + l) * 8 + b;
              if (rec_strb[f][l][b] != (pos >= vecs[i].off && pos < vecs[i].off + tot)) err++;
              if (rec_strb[f][l][b] && rec_data[f][l][8*b +: 8] != pat(f * 4 + l)[8*b +: 8])
                err++;
            end
        check($sformatf("v%0d_strb_data", i), err, 0);
      end
    end

    // vl=0: done one cycle after handshake, no beat requested
    @(negedge clk);
    req_valid = 1'b1; req_vl = '0; req_sew = EW16; req_off = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("vl0_done", int'(done), 1);
    check("vl0_mem_ready", int'(mem_ready), 0);
    check("vl0_req_ready", int'(req_ready), 1);
    @(negedge clk);
    check("vl0_done_pulse", int'(done), 0);

    // Back-pressure in FLUSH
    req_valid = 1'b1; req_vl = 32'd16; req_sew = EW8; req_off = '0;
    @(negedge clk);
    req_valid = 1'b0;
    to_flush(ok);
    check("stall_reach_flush", ok, 1);
    snap_d = lane_data[0]; snap_s = lane_strb[1];
    for (int c = 0; c < 3; c++) begin
      check("stall_mem_ready", int'(mem_ready), 0);
      check("stall_lane_valid", int'(lane_valid), 1);
      check("stall_data_stable", int'(lane_data[0] == snap_d && lane_strb[1] == snap_s), 1);
      @(negedge clk);
    end
`ifdef MEM_SHUF_SEQ_STALL_CNT_EN
    check("stall_cnt", int'(stall_cnt), 3);
`endif
    lane_ready = 1'b1;
    @(negedge clk);
    lane_ready = 1'b0;
    check("stall_done", int'(done), 1);

    // Reset mid-FLUSH
    @(negedge clk);
    req_valid = 1'b1; req_vl = 32'd40; req_sew = EW8; req_off = '0;
    @(negedge clk);
    req_valid = 1'b0;
    to_flush(ok);
    check("rstmid_reach_flush", ok, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("rstmid_lane_valid", int'(lane_valid), 0);
    check("rstmid_mem_ready", int'(mem_ready), 0);
    check("rstmid_strb0", int'(lane_strb[0]), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rstmid_req_ready", int'(req_ready), 1);
`ifdef MEM_SHUF_SEQ_STALL_CNT_EN
    check("rstmid_stall_cnt", int'(stall_cnt), 0);
`endif
    run_req(8, EW8, 3);
    check("post_rst_done", done_seen, 1);
    check("post_rst_beats", nb, 2);
    if (nb > 0) begin
      check("post_rst_sel0", int'(rec_sel[0]), 0);
      check("post_rst_first", int'(rec_first[0]), 1);
      check("post_rst_skip_first", int'(rec_sf[0]), 3);
    end
    if (nb == 2) check("post_rst_skip_last", int'(rec_sl[1]), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
